// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core.
// Opcodes, functs, FSM states and ALU helpers.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   typedef enum logic [3:0] {
      S_BOOT,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_BRANCH,
      S_JUMP,
      S_WB_ALU,
      S_WB_MEM,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   function automatic logic funct_legal(input logic [5:0] funct);
      return (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
             (funct == F_OR)  || (funct == F_SLT);
   endfunction

   function automatic alu_op_t alu_ctl(input logic [5:0] funct);
      alu_op_t op;
      case (funct)
         F_SUB:   op = ALU_SUB;
         F_AND:   op = ALU_AND;
         F_OR:    op = ALU_OR;
         F_SLT:   op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic logic [31:0] alu_eval(
      input logic [31:0] a,
      input logic [31:0] b,
      input alu_op_t     op
   );
      logic [31:0] y;
      case (op)
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_SLT: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: y = a + b;
      endcase
      return y;
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Control FSM of the multi-cycle core.
// Sequences states and owns retire/halted pulses.
module mc_ctrl_fsm
   import mips_pkg::*;
#(
   parameter bit TRAP_ON_ILLEGAL = 1'b1
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_mem_ready,
   input  logic       i_misal,
   output state_t     o_state,
   output logic       o_retire,
   output logic       o_halted
);

   state_t r_state;
   logic   r_retire;
   logic   r_halted;
   logic   w_legal;

   // Instruction legality from the fetched opcode/funct
   always_comb begin
      w_legal = 1'b0;
      case (i_opcode)
         OP_RTYPE: w_legal = funct_legal(i_funct);
         OP_ADDI,
         OP_LW,
         OP_SW,
         OP_BEQ,
         OP_J:     w_legal = 1'b1;
         default:  w_legal = 1'b0;
      endcase
   end

   // State sequencing with registered retire/halted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_BOOT;
         r_retire <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         r_retire <= 1'b0;
         case (r_state)
            S_BOOT:   r_state <= S_FETCH;
            S_FETCH:  if (i_mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               if (!w_legal) begin
                  if (TRAP_ON_ILLEGAL) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_state  <= S_FETCH;
                     r_retire <= 1'b1;
                  end
               end else begin
                  case (i_opcode)
                     OP_RTYPE:    r_state <= S_EXEC_R;
                     OP_ADDI:     r_state <= S_EXEC_I;
                     OP_LW, OP_SW: r_state <= S_ADDR;
                     OP_BEQ:      r_state <= S_BRANCH;
                     default:     r_state <= S_JUMP;
                  endcase
               end
            end
            S_EXEC_R, S_EXEC_I: r_state <= S_WB_ALU;
            S_ADDR: begin
               if (i_misal) begin
                  if (TRAP_ON_ILLEGAL) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_state  <= S_FETCH;
                     r_retire <= 1'b1;
                  end
               end else if (i_opcode == OP_LW) begin
                  r_state <= S_MEM_RD;
               end else begin
                  r_state <= S_MEM_WR;
               end
            end
            S_MEM_RD: if (i_mem_ready) r_state <= S_WB_MEM;
            S_MEM_WR: begin
               if (i_mem_ready) begin
                  r_state  <= S_FETCH;
                  r_retire <= 1'b1;
               end
            end
            S_BRANCH, S_JUMP, S_WB_ALU, S_WB_MEM: begin
               r_state  <= S_FETCH;
               r_retire <= 1'b1;
            end
            S_HALT: r_halted <= 1'b1;
            default: r_state <= S_BOOT;
         endcase
      end
   end

   assign o_state  = r_state;
   assign o_retire = r_retire;
   assign o_halted = r_halted;

endmodule

// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS-I subset core: datapath, register file, memory port.
// Sequencing lives in mc_ctrl_fsm.
module mips_multicycle_cpu
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int unsigned ADDR_W          = 32,
   parameter bit          TRAP_ON_ILLEGAL = 1'b1
)(
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              retire,
   output logic              halted,
   output logic [31:0]       pc_dbg
);

   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_alu_out;
   logic [31:0] r_mdr;
   logic [31:0] r_pc_dbg;
   logic [31:0] r_rf [32];

   state_t      w_state;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [4:0]  w_dest;
   logic [5:0]  w_opcode;
   logic [5:0]  w_funct;
   logic [31:0] w_imm_ext;
   logic [31:0] w_ea;
   logic [31:0] w_rf_wd;
   logic        w_rf_we;
   logic        w_misal;

   assign w_opcode  = r_ir[31:26];
   assign w_rs      = r_ir[25:21];
   assign w_rt      = r_ir[20:16];
   assign w_rd      = r_ir[15:11];
   assign w_funct   = r_ir[5:0];
   assign w_imm_ext = sext16(r_ir[15:0]);
   assign w_ea      = r_a + w_imm_ext;
   assign w_misal   = |w_ea[1:0];

   mc_ctrl_fsm #(
      .TRAP_ON_ILLEGAL (TRAP_ON_ILLEGAL)
   ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_opcode    (w_opcode),
      .i_funct     (w_funct),
      .i_mem_ready (mem_ready),
      .i_misal     (w_misal),
      .o_state     (w_state),
      .o_retire    (retire),
      .o_halted    (halted)
   );

   // Memory port decoded from state: fetch at PC, data at ALUOut
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (w_state)
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = r_pc[ADDR_W-1:0];
         end
         S_MEM_RD: begin
            mem_req  = 1'b1;
            mem_addr = r_alu_out[ADDR_W-1:0];
         end
         S_MEM_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_alu_out[ADDR_W-1:0];
            mem_wdata = r_b;
         end
         default: ;
      endcase
   end

   // Datapath registers updated per FSM state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc      <= RESET_PC;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_alu_out <= '0;
         r_mdr     <= '0;
         r_pc_dbg  <= RESET_PC;
      end else begin
         case (w_state)
            S_FETCH: begin
               if (mem_ready) begin
                  r_ir     <= mem_rdata;
                  r_pc     <= r_pc + 32'd4;
                  r_pc_dbg <= r_pc;
               end
            end
            S_DECODE: begin
               r_a       <= r_rf[w_rs];
               r_b       <= r_rf[w_rt];
               r_alu_out <= r_pc + (w_imm_ext << 2);
            end
            S_EXEC_R: r_alu_out <= alu_eval(r_a, r_b, alu_ctl(w_funct));
            S_EXEC_I, S_ADDR: r_alu_out <= w_ea;
            S_MEM_RD: if (mem_ready) r_mdr <= mem_rdata;
            S_BRANCH: if (r_a == r_b) r_pc <= r_alu_out;
            S_JUMP: r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
            default: ;
         endcase
      end
   end

   assign w_dest  = ((w_state == S_WB_MEM) || (w_opcode != OP_RTYPE)) ? w_rt : w_rd;
   assign w_rf_wd = (w_state == S_WB_MEM) ? r_mdr : r_alu_out;
   assign w_rf_we = ((w_state == S_WB_ALU) || (w_state == S_WB_MEM)) && (w_dest != 5'd0);

   // Register file; $0 never written so it always reads zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else if (w_rf_we) begin
         r_rf[w_dest] <= w_rf_wd;
      end
   end

   assign pc_dbg = r_pc_dbg;

endmodule
